// File: rtl/irq_ctrl_pkg.sv
// Shared encodings for the interrupt controller: register map, FSM states and the
// fixed-priority helper used when a request is latched.
package irq_ctrl_pkg;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_ID   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Lowest set index wins; scanning downwards lets the last hit be the lowest.
  function automatic logic [2:0] lowest_index(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus plus coprocessor handshake between the CPU side and the interrupt controller.
interface irq_ctrl_if;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic       eoi;
  logic       ir_out;
  logic [2:0] irq_id;
  logic       busy;

  modport master (
    output we, addr, wdata, ack, eoi,
    input  rdata, ir_out, irq_id, busy
  );

  modport slave (
    input  we, addr, wdata, ack, eoi,
    output rdata, ir_out, irq_id, busy
  );
endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector, one lane per bit.
module irq_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [1:0]       warm_q;

  // Edges only count once the pipeline holds three real post-reset samples, so a
  // line already high when reset releases never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= 2'd0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign rise = (warm_q == 2'd3) ? (sync_q & ~prev_q) : '0;

endmodule

// File: rtl/irq_ctrl.sv
// Single-level interrupt controller: pending/mask/enable registers and an
// IDLE/REQ/SERVICE handshake with the coprocessor's external interrupt input.
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  irq_ctrl_if.slave       bus
);
  import irq_ctrl_pkg::*;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] pend_d;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] sw_clr;
  logic            en_q;
  irq_state_t      state_q;
  irq_state_t      state_d;
  logic [2:0]      id_q;
  logic [2:0]      id_d;
  logic            ir_q;
  logic            ir_d;
  logic [7:0]      svc_clr;
  logic [7:0]      active;
  logic            wr_pend;
  logic            wr_mask;
  logic            wr_ctrl;

  irq_sync_edge #(.WIDTH(NSRC)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (src),
    .rise (rise)
  );

  assign wr_pend = bus.we && (bus.addr == ADDR_PEND);
  assign wr_mask = bus.we && (bus.addr == ADDR_MASK);
  assign wr_ctrl = bus.we && (bus.addr == ADDR_CTRL);
  assign sw_clr  = wr_pend ? bus.wdata[NSRC-1:0] : '0;

  always_comb begin
    active = '0;
    active[NSRC-1:0] = pend_q & mask_q;
  end

  // Next state: ack outranks a same-cycle disable, and eoi is only honoured in SERVICE.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ir_d    = ir_q;
    svc_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (en_q && (active != 8'd0)) begin
          state_d = REQ;
          id_d    = lowest_index(active);
          ir_d    = 1'b1;
        end
      end
      REQ: begin
        if (bus.ack) begin
          state_d       = SERVICE;
          ir_d          = 1'b0;
          svc_clr[id_q] = 1'b1;
        end else if (wr_ctrl && !bus.wdata[0]) begin
          state_d = IDLE;
          ir_d    = 1'b0;
        end
      end
      SERVICE: begin
        if (bus.eoi) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ir_d    = 1'b0;
      end
    endcase
  end

  // A hardware edge is OR-ed in last so it survives both W1C and the ack clear.
  assign pend_d = (pend_q & ~sw_clr & ~svc_clr[NSRC-1:0]) | rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= 3'd0;
      ir_q    <= 1'b0;
      pend_q  <= '0;
      mask_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ir_q    <= ir_d;
      pend_q  <= pend_d;
      if (wr_mask) mask_q <= bus.wdata[NSRC-1:0];
      if (wr_ctrl) en_q <= bus.wdata[0];
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_PEND: bus.rdata[NSRC-1:0] = pend_q;
      ADDR_MASK: bus.rdata[NSRC-1:0] = mask_q;
      ADDR_ID:   bus.rdata[2:0]      = id_q;
      ADDR_CTRL: bus.rdata[0]        = en_q;
      default:   bus.rdata           = '0;
    endcase
  end

  assign bus.ir_out = ir_q;
  assign bus.irq_id = id_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus randomised traffic for irq_ctrl, checked against a
// behavioural model stepped on every rising clock edge.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src = 8'h00;

  irq_ctrl_if bus ();

  irq_ctrl #(.NSRC(8)) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd [4];

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_mask = 8'h00;
  logic       m_en   = 1'b0;
  int         m_mode = M_IDLE;
  logic [2:0] m_id   = 3'd0;
  logic       m_ir   = 1'b0;
  logic [7:0] hist [$];

  logic [7:0] r_s;
  logic       r_w;
  logic [1:0] r_a;
  logic [7:0] r_d;
  logic       r_ack;
  logic       r_eoi;

  function automatic logic [2:0] first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  function automatic logic [7:0] modelReg(input int r);
    case (r)
      0:       return m_pend;
      1:       return m_mask;
      2:       return {5'd0, m_id};
      default: return {7'd0, m_en};
    endcase
  endfunction

  task automatic modelReset();
    m_pend = 8'h00;
    m_mask = 8'h00;
    m_en   = 1'b0;
    m_mode = M_IDLE;
    m_id   = 3'd0;
    m_ir   = 1'b0;
    hist.delete();
  endtask

  // A source counts as risen when it was sampled high two edges ago after being low
  // the edge before that, and only once three post-reset samples exist.
  task automatic modelStep();
    int         n;
    logic [7:0] rises;
    logic [7:0] nxt;
    n     = hist.size() + 1;
    rises = 8'h00;
    if (n >= 4) rises = hist[n-3] & ~hist[n-4];
    hist.push_back(src);
    nxt = m_pend;
    if (bus.we && bus.addr == 2'd0) nxt = nxt & ~bus.wdata;
    case (m_mode)
      M_IDLE: begin
        if (m_en && ((m_pend & m_mask) != 8'h00)) begin
          m_mode = M_REQ;
          m_ir   = 1'b1;
          m_id   = first_set(m_pend & m_mask);
        end
      end
      M_REQ: begin
        if (bus.ack) begin
          m_mode    = M_SVC;
          m_ir      = 1'b0;
          nxt[m_id] = 1'b0;
        end else if (bus.we && bus.addr == 2'd3 && !bus.wdata[0]) begin
          m_mode = M_IDLE;
          m_ir   = 1'b0;
        end
      end
      default: begin
        if (bus.eoi) m_mode = M_IDLE;
      end
    endcase
    m_pend = nxt | rises;
    if (bus.we && bus.addr == 2'd1) m_mask = bus.wdata;
    if (bus.we && bus.addr == 2'd3) m_en = bus.wdata[0];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic w, input logic [1:0] a,
                               input logic [7:0] d, input logic k_ack, input logic k_eoi);
    @(negedge clk);
    src       = s;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.ack   = k_ack;
    bus.eoi   = k_eoi;
    @(posedge clk);
    modelStep();
    #1;
    bus.we  = 1'b0;
    bus.ack = 1'b0;
    bus.eoi = 1'b0;
    checkOutput("ir_out", 32'(bus.ir_out), 32'(m_ir));
    checkOutput("irq_id", 32'(bus.irq_id), 32'(m_id));
    checkOutput("busy", 32'(bus.busy), 32'(m_mode != M_IDLE));
    for (int r = 0; r < 4; r++) begin
      bus.addr = 2'(r);
      #1;
      rd[r] = bus.rdata;
      checkOutput($sformatf("rdata[%0d]", r), 32'(bus.rdata), 32'(modelReg(r)));
    end
  endtask

  task automatic holdSrc(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) applyStimulus(s, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
    applyStimulus(src, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic pulseAck();
    applyStimulus(src, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic pulseEoi();
    applyStimulus(src, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ir_out"}, 32'(bus.ir_out), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " irq_id"}, 32'(bus.irq_id), 32'd0);
    for (int r = 0; r < 4; r++) begin
      bus.addr = 2'(r);
      #1;
      checkOutput($sformatf("%s rdata[%0d]", tag, r), 32'(bus.rdata), 32'd0);
    end
  endtask

  initial begin
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 8'h00;
    bus.ack   = 1'b0;
    bus.eoi   = 1'b0;

    #1 rst = 1'b0;
    modelReset();
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    holdSrc(8'h00, 3);

    // Single source, enabled: pending after three edges, request on the fourth.
    $display("[TB] single source request");
    writeReg(2'd1, 8'h01);
    writeReg(2'd3, 8'h01);
    holdSrc(8'h01, 3);
    checkOutput("single pend0", 32'(rd[0][0]), 32'd1);
    checkOutput("single ir_before", 32'(bus.ir_out), 32'd0);
    holdSrc(8'h01, 1);
    checkOutput("single ir_out", 32'(bus.ir_out), 32'd1);
    checkOutput("single irq_id", 32'(bus.irq_id), 32'd0);
    pulseAck();
    pulseEoi();
    holdSrc(8'h00, 3);

    // Two sources together: lowest first, the other follows after a low gap.
    $display("[TB] priority and re-request");
    writeReg(2'd1, 8'hFF);
    holdSrc(8'h24, 4);
    checkOutput("prio irq_id", 32'(bus.irq_id), 32'd2);
    checkOutput("prio ir_out", 32'(bus.ir_out), 32'd1);
    pulseAck();
    pulseEoi();
    checkOutput("gap ir_out", 32'(bus.ir_out), 32'd0);
    holdSrc(8'h24, 1);
    checkOutput("second ir_out", 32'(bus.ir_out), 32'd1);
    checkOutput("second irq_id", 32'(bus.irq_id), 32'd5);
    pulseAck();
    pulseEoi();
    holdSrc(8'h00, 3);

    // Clear write colliding with a detected edge on the same bit.
    $display("[TB] set beats clear");
    holdSrc(8'h04, 2);
    applyStimulus(8'h04, 1'b1, 2'd0, 8'h04, 1'b0, 1'b0);
    checkOutput("collide pend2", 32'(rd[0][2]), 32'd1);
    holdSrc(8'h04, 1);
    pulseAck();
    pulseEoi();
    holdSrc(8'h00, 3);

    // Disable while requesting, then re-enable.
    $display("[TB] disable in REQ");
    holdSrc(8'h08, 4);
    checkOutput("dis pre irq_id", 32'(bus.irq_id), 32'd3);
    writeReg(2'd3, 8'h00);
    checkOutput("dis ir_out", 32'(bus.ir_out), 32'd0);
    checkOutput("dis busy", 32'(bus.busy), 32'd0);
    checkOutput("dis pend", 32'(rd[0]), 32'h08);
    writeReg(2'd3, 8'h01);
    checkOutput("reen ir_first", 32'(bus.ir_out), 32'd0);
    holdSrc(8'h08, 1);
    checkOutput("reen ir_out", 32'(bus.ir_out), 32'd1);
    checkOutput("reen irq_id", 32'(bus.irq_id), 32'd3);
    pulseAck();
    pulseEoi();
    holdSrc(8'h00, 3);

    // Asynchronous reset in SERVICE with the source left high afterwards.
    $display("[TB] reset during service");
    holdSrc(8'h40, 4);
    pulseAck();
    checkOutput("svc busy", 32'(bus.busy), 32'd1);
    #7 rst = 1'b0;
    modelReset();
    #1;
    checkResetOutputs("async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    holdSrc(8'h40, 8);
    checkOutput("post-reset pend", 32'(rd[0]), 32'd0);

    // Stray handshakes in the wrong states.
    $display("[TB] ignored handshakes");
    pulseEoi();
    checkOutput("eoi idle busy", 32'(bus.busy), 32'd0);
    checkOutput("eoi idle ir", 32'(bus.ir_out), 32'd0);
    writeReg(2'd1, 8'h02);
    writeReg(2'd3, 8'h01);
    holdSrc(8'h42, 4);
    checkOutput("stray irq_id", 32'(bus.irq_id), 32'd1);
    pulseEoi();
    checkOutput("eoi req ir", 32'(bus.ir_out), 32'd1);
    pulseAck();
    pulseAck();
    checkOutput("ack svc busy", 32'(bus.busy), 32'd1);
    checkOutput("ack svc ir", 32'(bus.ir_out), 32'd0);
    pulseEoi();
    holdSrc(8'h00, 3);

    // Randomised traffic; handshakes favour the states where they matter.
    $display("[TB] random traffic");
    for (int c = 0; c < 800; c++) begin
      r_s = src;
      if ($urandom_range(0, 3) == 0) r_s = r_s ^ (8'($urandom) & 8'($urandom));
      r_w = ($urandom_range(0, 5) == 0);
      r_a = 2'($urandom);
      r_d = 8'($urandom);
      if (r_a == 2'd3) r_d[0] = ($urandom_range(0, 3) != 0);
      r_ack = (m_mode == M_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      r_eoi = (m_mode == M_SVC) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      if (r_ack) r_w = 1'b0;
      applyStimulus(r_s, r_w, r_a, r_d, r_ack, r_eoi);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
